// File: rtl/clock_display_pkg.sv
//------------------------------------------------------------------------------
// clock_display_pkg : shared types and segment encodings for the time display
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clock_display_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    CONV_SEC = 3'd2,
    CONV_MIN = 3'd3,
    CONV_HR  = 3'd4,
    COMMIT   = 3'd5
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low segments, bit0 = a .. bit6 = g
  function automatic logic [6:0] seg_lut(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_display_seg7_decode.sv
//------------------------------------------------------------------------------
// seg7_decode : one BCD digit to active-low 7-segment, with dash/blank override
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg7_decode
  import clock_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  // A dash marks an invalid field and must win over lead-zero blanking
  always_comb begin
    seg_o = seg_lut(digit_i);
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else if (blank_i) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clock_display.sv
//------------------------------------------------------------------------------
// clock_display : snapshots sec/min/hr, converts sequentially, commits 6 digits
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clock_display
  import clock_display_pkg::*;
#(
  parameter int BLANK_HR_LEAD = 1,
  parameter int FIELD_CYC     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hr,
  input  logic       mode_12h,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       pm,
  output logic       busy
);

  localparam int              CNT_W    = (FIELD_CYC > 1) ? $clog2(FIELD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FIELD_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             snap_valid_q, snap_valid_d;
  logic [5:0]       snap_sec_q, snap_sec_d;
  logic [5:0]       snap_min_q, snap_min_d;
  logic [4:0]       snap_hr_q, snap_hr_d;
  logic             snap_12h_q, snap_12h_d;
  logic [5:0]       sec_rem_q, sec_rem_d;
  logic [5:0]       min_rem_q, min_rem_d;
  logic [4:0]       hr_rem_q, hr_rem_d;
  logic [2:0]       sec_tens_q, sec_tens_d;
  logic [2:0]       min_tens_q, min_tens_d;
  logic [2:0]       hr_tens_q, hr_tens_d;
  logic             sec_bad_q, sec_bad_d;
  logic             min_bad_q, min_bad_d;
  logic             hr_bad_q, hr_bad_d;
  logic             pm_pend_q, pm_pend_d;
  logic             busy_q, busy_d;
  logic             pm_q, pm_d;
  logic [6:0]       hex_q [6];
  logic [6:0]       hex_d [6];

  logic [3:0]       w_dig   [6];
  logic             w_blank [6];
  logic             w_dash  [6];
  logic [6:0]       w_seg   [6];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      snap_valid_q <= 1'b0;
      snap_sec_q   <= '0;
      snap_min_q   <= '0;
      snap_hr_q    <= '0;
      snap_12h_q   <= 1'b0;
      sec_rem_q    <= '0;
      min_rem_q    <= '0;
      hr_rem_q     <= '0;
      sec_tens_q   <= '0;
      min_tens_q   <= '0;
      hr_tens_q    <= '0;
      sec_bad_q    <= 1'b0;
      min_bad_q    <= 1'b0;
      hr_bad_q     <= 1'b0;
      pm_pend_q    <= 1'b0;
      busy_q       <= 1'b0;
      pm_q         <= 1'b0;
      for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      snap_valid_q <= snap_valid_d;
      snap_sec_q   <= snap_sec_d;
      snap_min_q   <= snap_min_d;
      snap_hr_q    <= snap_hr_d;
      snap_12h_q   <= snap_12h_d;
      sec_rem_q    <= sec_rem_d;
      min_rem_q    <= min_rem_d;
      hr_rem_q     <= hr_rem_d;
      sec_tens_q   <= sec_tens_d;
      min_tens_q   <= min_tens_d;
      hr_tens_q    <= hr_tens_d;
      sec_bad_q    <= sec_bad_d;
      min_bad_q    <= min_bad_d;
      hr_bad_q     <= hr_bad_d;
      pm_pend_q    <= pm_pend_d;
      busy_q       <= busy_d;
      pm_q         <= pm_d;
      for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    snap_valid_d = snap_valid_q;
    snap_sec_d   = snap_sec_q;
    snap_min_d   = snap_min_q;
    snap_hr_d    = snap_hr_q;
    snap_12h_d   = snap_12h_q;
    sec_rem_d    = sec_rem_q;
    min_rem_d    = min_rem_q;
    hr_rem_d     = hr_rem_q;
    sec_tens_d   = sec_tens_q;
    min_tens_d   = min_tens_q;
    hr_tens_d    = hr_tens_q;
    sec_bad_d    = sec_bad_q;
    min_bad_d    = min_bad_q;
    hr_bad_d     = hr_bad_q;
    pm_pend_d    = pm_pend_q;
    busy_d       = busy_q;
    pm_d         = pm_q;
    for (int i = 0; i < 6; i++) hex_d[i] = hex_q[i];

    case (state_q)
      IDLE: begin
        if (!snap_valid_q ||
            ({sec, min, hr, mode_12h} != {snap_sec_q, snap_min_q, snap_hr_q, snap_12h_q})) begin
          snap_sec_d   = sec;
          snap_min_d   = min;
          snap_hr_d    = hr;
          snap_12h_d   = mode_12h;
          snap_valid_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = LOAD;
        end
      end

      LOAD: begin
        sec_bad_d  = (snap_sec_q > 6'd59);
        min_bad_d  = (snap_min_q > 6'd59);
        hr_bad_d   = (snap_hr_q > 5'd23);
        sec_rem_d  = snap_sec_q;
        min_rem_d  = snap_min_q;
        hr_rem_d   = snap_hr_q;
        sec_tens_d = '0;
        min_tens_d = '0;
        hr_tens_d  = '0;
        pm_pend_d  = 1'b0;
        // 12h fold: 0 -> 12 AM, 12 -> 12 PM, 13..23 -> 1..11 PM
        if (!hr_bad_d && snap_12h_q) begin
          if (snap_hr_q == 5'd0) begin
            hr_rem_d = 5'd12;
          end else if (snap_hr_q >= 5'd13) begin
            hr_rem_d  = snap_hr_q - 5'd12;
            pm_pend_d = 1'b1;
          end else if (snap_hr_q == 5'd12) begin
            pm_pend_d = 1'b1;
          end
        end
        cnt_d   = '0;
        state_d = CONV_SEC;
      end

      CONV_SEC: begin
        if (sec_rem_q >= 6'd10) begin
          sec_rem_d  = sec_rem_q - 6'd10;
          sec_tens_d = sec_tens_q + 3'd1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = CONV_MIN;
        end
      end

      CONV_MIN: begin
        if (min_rem_q >= 6'd10) begin
          min_rem_d  = min_rem_q - 6'd10;
          min_tens_d = min_tens_q + 3'd1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = CONV_HR;
        end
      end

      CONV_HR: begin
        if (hr_rem_q >= 5'd10) begin
          hr_rem_d  = hr_rem_q - 5'd10;
          hr_tens_d = hr_tens_q + 3'd1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        for (int i = 0; i < 6; i++) hex_d[i] = w_seg[i];
        pm_d    = pm_pend_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    w_dig[0]   = 4'(sec_rem_q);
    w_dig[1]   = 4'(sec_tens_q);
    w_dig[2]   = 4'(min_rem_q);
    w_dig[3]   = 4'(min_tens_q);
    w_dig[4]   = 4'(hr_rem_q);
    w_dig[5]   = 4'(hr_tens_q);
    w_dash[0]  = sec_bad_q;
    w_dash[1]  = sec_bad_q;
    w_dash[2]  = min_bad_q;
    w_dash[3]  = min_bad_q;
    w_dash[4]  = hr_bad_q;
    w_dash[5]  = hr_bad_q;
    for (int i = 0; i < 5; i++) w_blank[i] = 1'b0;
    w_blank[5] = snap_12h_q && (BLANK_HR_LEAD != 0) && (hr_tens_q == 3'd0);
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_digit
    seg7_decode u_seg (
      .digit_i (w_dig[gi]),
      .blank_i (w_blank[gi]),
      .dash_i  (w_dash[gi]),
      .seg_o   (w_seg[gi])
    );
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign pm   = pm_q;
  assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_display.sv
//------------------------------------------------------------------------------
// tb_clock_display : vector table, corner sequences and random vs. model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_clock_display;

  localparam int B_LEAD = 1;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [4:0] hr  = '0;
  logic       mode_12h = 1'b0;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic       pm, busy;

  int checks = 0;
  int errors = 0;

  clock_display #(.BLANK_HR_LEAD(B_LEAD), .FIELD_CYC(6)) dut (
    .clk(clk), .rst(rst), .sec(sec), .min(min), .hr(hr), .mode_12h(mode_12h),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .pm(pm), .busy(busy)
  );

  always #5 clk = ~clk;

  wire logic [41:0] hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  typedef struct {
    logic [5:0]  s;
    logic [5:0]  m;
    logic [4:0]  h;
    logic        m12;
    logic [41:0] ehex;
    logic        epm;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BL;
    endcase
  endfunction

  // Returns {pm, HEX5..HEX0} as the display should read for the given time
  function automatic logic [42:0] model(input int s, input int m, input int h, input bit m12);
    logic [6:0] d [6];
    logic p;
    int hh;
    p = 1'b0;
    if (s > 59) begin d[1] = DS; d[0] = DS; end
    else begin d[1] = seg(s / 10); d[0] = seg(s % 10); end
    if (m > 59) begin d[3] = DS; d[2] = DS; end
    else begin d[3] = seg(m / 10); d[2] = seg(m % 10); end
    if (h > 23) begin
      d[5] = DS; d[4] = DS;
    end else if (m12) begin
      hh = h % 12;
      if (hh == 0) hh = 12;
      p = (h >= 12);
      d[5] = (hh < 10 && B_LEAD != 0) ? BL : seg(hh / 10);
      d[4] = seg(hh % 10);
    end else begin
      d[5] = seg(h / 10);
      d[4] = seg(h % 10);
    end
    return {p, d[5], d[4], d[3], d[2], d[1], d[0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Waits for a conversion the last input change should have started
  task automatic wait_conv(input string tag);
    int n;
    n = 0;
    while (!busy && n < 4) begin @(posedge clk); #1; n++; end
    if (!busy) begin
      chk({tag, " start"}, 64'(busy), 64'd1);
      return;
    end
    n = 0;
    while (busy && n < 60) begin @(posedge clk); #1; n++; end
    chk({tag, " latency"}, 64'(n), 64'd20);
  endtask

  task automatic apply(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h,
                       input logic m12, input logic [42:0] exp, input string tag);
    @(negedge clk);
    if ({s, m, h, m12} != {sec, min, hr, mode_12h}) begin
      sec = s; min = m; hr = h; mode_12h = m12;
      wait_conv(tag);
      @(negedge clk);
    end
    chk({tag, " hex"}, 64'(hex_all), 64'(exp[41:0]));
    chk({tag, " pm"}, 64'(pm), 64'(exp[42]));
    chk({tag, " busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] rs, rm;
    logic [4:0] rh;
    logic       r12;

    tbl[0] = '{6'd9,  6'd5,  5'd13, 1'b1, {BL,    7'h79, 7'h40, 7'h12, 7'h40, 7'h10}, 1'b1};
    tbl[1] = '{6'd9,  6'd5,  5'd13, 1'b0, {7'h79, 7'h30, 7'h40, 7'h12, 7'h40, 7'h10}, 1'b0};
    tbl[2] = '{6'd0,  6'd0,  5'd0,  1'b1, {7'h79, 7'h24, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
    tbl[3] = '{6'd0,  6'd0,  5'd12, 1'b1, {7'h79, 7'h24, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b1};
    tbl[4] = '{6'd59, 6'd59, 5'd11, 1'b1, {7'h79, 7'h79, 7'h12, 7'h10, 7'h12, 7'h10}, 1'b0};
    tbl[5] = '{6'd62, 6'd30, 5'd7,  1'b0, {7'h40, 7'h78, 7'h30, 7'h40, DS,    DS   }, 1'b0};
    tbl[6] = '{6'd0,  6'd0,  5'd25, 1'b1, {DS,    DS,    7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
    tbl[7] = '{6'd45, 6'd60, 5'd23, 1'b1, {7'h79, 7'h79, DS,    DS,    7'h19, 7'h12}, 1'b1};
    tbl[8] = '{6'd3,  6'd7,  5'd9,  1'b1, {BL,    7'h10, 7'h40, 7'h78, 7'h40, 7'h30}, 1'b0};

    // Reset state and first conversion timing
    repeat (3) @(posedge clk);
    #1;
    chk("reset hex", 64'(hex_all), {22'd0, {6{BL}}});
    chk("reset pm", 64'(pm), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("edge1 busy", 64'(busy), 64'd1);
    repeat (19) @(posedge clk);
    #1;
    chk("edge20 busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("edge21 hex", 64'(hex_all), 64'(model(0, 0, 0, 1'b0) & 43'h3FF_FFFF_FFFF));
    chk("edge21 pm", 64'(pm), 64'd0);
    chk("edge21 busy", 64'(busy), 64'd0);

    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].s, tbl[i].m, tbl[i].h, tbl[i].m12, {tbl[i].epm, tbl[i].ehex},
            $sformatf("vec%0d", i));
    end

    // Input change during conversion is held off until the next IDLE compare
    @(negedge clk);
    sec = 6'd10; min = 6'd0; hr = 5'd0; mode_12h = 1'b0;
    @(posedge clk); #1;
    chk("midchg capture busy", 64'(busy), 64'd1);
    repeat (4) @(posedge clk);
    @(negedge clk) sec = 6'd11;
    repeat (16) @(posedge clk);
    #1;
    chk("midchg first busy", 64'(busy), 64'd0);
    chk("midchg first sec", 64'({HEX1, HEX0}), 64'({7'h79, 7'h40}));
    chk("midchg first hex", 64'(hex_all), 64'(model(10, 0, 0, 1'b0) & 43'h3FF_FFFF_FFFF));
    @(posedge clk); #1;
    chk("midchg busy gap", 64'(busy), 64'd1);
    repeat (19) @(posedge clk);
    #1;
    chk("midchg second pending", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("midchg second busy", 64'(busy), 64'd0);
    chk("midchg second hex", 64'(hex_all), 64'(model(11, 0, 0, 1'b0) & 43'h3FF_FFFF_FFFF));

    // Reset mid-conversion discards work, then a fresh conversion runs
    @(negedge clk);
    sec = 6'd33; min = 6'd44; hr = 5'd22; mode_12h = 1'b1;
    @(posedge clk); #1;
    chk("rstmid capture busy", 64'(busy), 64'd1);
    repeat (7) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid hex", 64'(hex_all), {22'd0, {6{BL}}});
    chk("rstmid pm", 64'(pm), 64'd0);
    chk("rstmid busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rstrel capture busy", 64'(busy), 64'd1);
    repeat (19) @(posedge clk);
    #1;
    chk("rstrel pending", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("rstrel busy", 64'(busy), 64'd0);
    chk("rstrel hex", 64'(hex_all), 64'(model(33, 44, 22, 1'b1) & 43'h3FF_FFFF_FFFF));
    chk("rstrel pm", 64'(pm), 64'd1);

    // Randomised times, mostly in range with occasional invalid fields
    for (int i = 0; i < 40; i++) begin
      rs  = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 59));
      rm  = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 59));
      rh  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 23));
      r12 = 1'($urandom_range(0, 1));
      apply(rs, rm, rh, r12, model(int'(rs), int'(rm), int'(rh), r12), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
